seq_edge_counter: RTL and testbench
===================================

SEQ_EDGE_COUNTER -- requirements
Module: seq_edge_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, edge-count width (2..16).
REQ-002 SHALL have parameter WINDOW, default 16, measurement window length in cycles (2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port en  input  1  start/continue measurement windows.
REQ-006 SHALL have port d  input  1  registered serial bit from the upstream flop stage.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port out_count  output  CNT_W  edges counted in the last window.
REQ-010 SHALL have port out_ovf  output  1  count saturated in the last window.

Function
REQ-011 SHALL register d once (d_q) and detect a rising edge as d & ~d_q, so the first window cycle never counts an edge that occurred before the window started.
REQ-012 SHALL implement FSM states IDLE, COUNT, HOLD.
REQ-013 IDLE: en=1 -> COUNT next cycle, with window counter and edge counter cleared; en=0 -> stay.
REQ-014 COUNT: window counter increments every cycle; edges detected in that cycle are added to the edge counter.
REQ-015 COUNT: at window counter == WINDOW-1, the edge from that cycle is included, out_count/out_ovf are loaded, and the FSM moves to HOLD.
REQ-016 Window latency SHALL be exactly WINDOW cycles in COUNT; out_valid rises the cycle after the last window cycle.
REQ-017 HOLD: out_valid=1, and out_count/out_ovf SHALL stay stable until out_valid & out_ready.
REQ-018 On handshake: en=1 -> COUNT (counters cleared); en=0 -> IDLE; out_valid drops the next cycle.
REQ-019 Edge counter SHALL saturate at 2^CNT_W-1 and set a sticky overflow flag for the window; no wrap-around.
REQ-020 en deasserted mid-COUNT SHALL NOT abort; the window completes and the result is delivered.
REQ-021 Edges arriving during IDLE/HOLD SHALL be ignored, but d_q keeps tracking d.
REQ-022 out_ready while not in HOLD SHALL have no effect.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, d_q=0, counters=0, out_valid=0, out_count=0, out_ovf=0.
REQ-024 rst SHALL override every state, including mid-window and HOLD, and any pending result SHALL be discarded.
REQ-025 Outputs SHALL be driven only from registers.

Configuration
REQ-026 Macro SEQ_EDGE_COUNTER_FALL_EN: when defined, falling edges (~d & d_q) also count, so each toggle adds 1.
REQ-027 Without SEQ_EDGE_COUNTER_FALL_EN, only rising edges count.

Structure
REQ-028 Package seq_edge_pkg SHALL hold the state enum typedef (IDLE=2'd0, COUNT=2'd1, HOLD=2'd2) and the CNT_W/WINDOW default constants.
REQ-029 Edge detection (d_q register plus edge pulse, including the FALL_EN option) SHALL be sub-module seq_edge_detect.
REQ-030 The FSM and counters SHALL use one sequential process with a single timing control, plus a combinational next-state process; no multi-statement timed blocks.

Verification
REQ-031 Reset mid-window: en=1, 5 edges, rst at cycle 8 -> all outputs 0, state IDLE; the next window counts from 0.
REQ-032 Basic count: WINDOW=16, d toggles every cycle from the first COUNT cycle -> out_count=8 (16 with FALL_EN), out_ovf=0, out_valid at cycle 17.
REQ-033 Saturation: CNT_W=2, 6 rising edges in a window -> out_count=3, out_ovf=1.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid and out_count stable; out_ready=1 -> handshake, new window starts if en=1.
REQ-035 Boundary edge: single rising edge exactly in cycle WINDOW-1 -> out_count=1; edge one cycle after the window -> not counted.
REQ-036 en drop: en=0 at COUNT cycle 3 -> window finishes, result delivered, FSM returns to IDLE after the handshake.

Source files
------------

// File: rtl/seq_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_edge_pkg
// Purpose  : Shared types and default constants for the windowed edge
//            counter: FSM state encoding and CNT_W / WINDOW defaults.
// Ports    : (package - none)
// Config   : SEQ_EDGE_COUNTER_FALL_EN (consumed by seq_edge_detect)
// Revision : 1.0 - initial release
// ============================================================================
package seq_edge_pkg;

  // Explicit 2-bit encoding so HOLD/COUNT decode is stable across tools.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT  = 8;
  localparam int WINDOW_DEFAULT = 16;

endpackage : seq_edge_pkg
`default_nettype wire

// File: rtl/seq_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : seq_edge_detect
// Purpose  : Registers the serial input once and produces a one-cycle edge
//            pulse comparing the current bit against the registered copy.
//            The registered copy tracks d in every cycle, independent of
//            whether the parent is counting.
// Ports    : clk        in   clock, rising edge
//            rst        in   synchronous active-high reset (clears d_q)
//            d          in   serial bit
//            edge_pulse out  edge seen this cycle (rising, or any toggle
//                            when SEQ_EDGE_COUNTER_FALL_EN is defined)
// Config   : SEQ_EDGE_COUNTER_FALL_EN - count falling edges as well
// Revision : 1.0 - initial release
// ============================================================================
module seq_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_pulse
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

`ifdef SEQ_EDGE_COUNTER_FALL_EN
  // Rising or falling: every toggle is one edge.
  assign edge_pulse = (d & ~d_q) | (~d & d_q);
`else
  assign edge_pulse = d & ~d_q;
`endif

endmodule : seq_edge_detect
`default_nettype wire

// File: rtl/seq_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_edge_counter
// Purpose  : Counts edges of a serial bit over a fixed window of WINDOW
//            cycles and presents the (saturating) result with a valid/ready
//            handshake. A started window always completes; rst discards
//            everything.
// Params   : CNT_W  (2..16)     edge-count width
//            WINDOW (2..65535)  window length in cycles
// Ports    : clk        in   clock, rising edge
//            rst        in   synchronous active-high reset
//            en         in   start / continue measurement windows
//            d          in   serial bit
//            out_valid  out  result available (held until accepted)
//            out_ready  in   consumer accepts result
//            out_count  out  edges counted in the last window
//            out_ovf    out  count saturated in the last window
// Config   : SEQ_EDGE_COUNTER_FALL_EN - falling edges also count
// Revision : 1.0 - initial release
// ============================================================================
module seq_edge_counter
  import seq_edge_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic edge_pulse;

  state_e             state_q,     state_d;
  logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q,  edge_cnt_d;
  logic               ovf_q,       ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q,   out_ovf_d;

  // Saturating accumulate of this cycle's edge, shared by the
  // mid-window update and the final-cycle result load.
  logic               at_max;
  logic [CNT_W-1:0]   cnt_acc;
  logic               ovf_acc;

  seq_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    at_max  = (edge_cnt_q == CNT_MAX);
    cnt_acc = (edge_pulse && !at_max) ? (edge_cnt_q + CNT_ONE) : edge_cnt_q;
    ovf_acc = ovf_q | (edge_pulse & at_max);
  end

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = COUNT;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end

      COUNT: begin
        // en is deliberately ignored here: a started window always completes.
        win_cnt_d  = win_cnt_q + WIN_ONE;
        edge_cnt_d = cnt_acc;
        ovf_d      = ovf_acc;
        if (win_cnt_q == WIN_LAST) begin
          // Last window cycle: its own edge is part of the result.
          out_count_d = cnt_acc;
          out_ovf_d   = ovf_acc;
          out_valid_d = 1'b1;
          win_cnt_d   = '0;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (en) begin
            state_d    = COUNT;
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule : seq_edge_counter
`default_nettype wire

// File: tb/tb_seq_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_edge_counter
// Purpose  : Self-checking bench for seq_edge_counter. Two instances share
//            all inputs: a wide counter (CNT_W=8) and a narrow one (CNT_W=2)
//            so every window also exercises saturation. Expected results
//            come from counting edges in the driven bit pattern.
// Config   : SEQ_EDGE_COUNTER_FALL_EN - model counts every toggle
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_edge_counter;

  localparam int WIN  = 16;
  localparam int CW_A = 8;
  localparam int CW_B = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            d;
  logic            out_ready;
  logic            valid_a, valid_b;
  logic [CW_A-1:0] count_a;
  logic [CW_B-1:0] count_b;
  logic            ovf_a, ovf_b;

  int   checks   = 0;
  int   failures = 0;
  logic last_d   = 1'b0;  // d as seen by the DUT's register at the last edge
  int   exp_a, exp_b;
  logic exp_ovf_a, exp_ovf_b;

  always #5 clk = ~clk;

  seq_edge_counter #(.CNT_W(CW_A), .WINDOW(WIN)) dut_a (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .out_valid(valid_a), .out_ready(out_ready),
    .out_count(count_a), .out_ovf(ovf_a)
  );

  seq_edge_counter #(.CNT_W(CW_B), .WINDOW(WIN)) dut_b (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .out_valid(valid_b), .out_ready(out_ready),
    .out_count(count_b), .out_ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    last_d = rst ? 1'b0 : d;
    #1;
  endtask

  // Edges in a bit pattern, given the bit that preceded it.
  function automatic int model_edges(input logic [WIN-1:0] p, input logic prev);
    int   c  = 0;
    logic pv = prev;
    for (int i = 0; i < WIN; i++) begin
      if (p[i] && !pv) c++;
`ifdef SEQ_EDGE_COUNTER_FALL_EN
      if (!p[i] && pv) c++;
`endif
      pv = p[i];
    end
    return c;
  endfunction

  // IDLE cycle with en=1; the next cycle is the first window cycle.
  task automatic start_idle(input logic x0);
    en        = 1'b1;
    d         = x0;
    out_ready = 1'($urandom);
    tick();
  endtask

  // Drive one full window, then check result of both instances.
  task automatic count_window(input logic [WIN-1:0] p, input int en_drop_at, input string name);
    int raw;
    raw = model_edges(p, last_d);
    for (int i = 0; i < WIN; i++) begin
      d = p[i];
      if (i == en_drop_at) en = 1'b0;
      out_ready = 1'($urandom);  // no effect outside HOLD
      tick();
      if (i < WIN - 1) begin
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
          failures++;
          $display("FAIL %s early_valid cycle=%0d got a=%b b=%b want 0", name, i, valid_a, valid_b);
        end
      end
    end
    out_ready = 1'b0;
    exp_a     = (raw > 255) ? 255 : raw;
    exp_ovf_a = (raw > 255);
    exp_b     = (raw > 3) ? 3 : raw;
    exp_ovf_b = (raw > 3);
    checks++;
    if (valid_a !== 1'b1 || valid_b !== 1'b1) begin
      failures++;
      $display("FAIL %s valid got a=%b b=%b want 1", name, valid_a, valid_b);
    end
    checks++;
    if (count_a !== CW_A'(exp_a) || ovf_a !== exp_ovf_a) begin
      failures++;
      $display("FAIL %s wide got cnt=%0d ovf=%b want cnt=%0d ovf=%b", name, count_a, ovf_a, exp_a, exp_ovf_a);
    end
    checks++;
    if (count_b !== CW_B'(exp_b) || ovf_b !== exp_ovf_b) begin
      failures++;
      $display("FAIL %s narrow got cnt=%0d ovf=%b want cnt=%0d ovf=%b", name, count_b, ovf_b, exp_b, exp_ovf_b);
    end
  endtask

  task automatic handshake(input logic en_v, input logic x, input string name);
    out_ready = 1'b1;
    en        = en_v;
    d         = x;
    tick();
    out_ready = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      failures++;
      $display("FAIL %s valid_drop got a=%b b=%b want 0", name, valid_a, valid_b);
    end
  endtask

  // en low: FSM must sit in IDLE, no result may appear.
  task automatic expect_quiet(input int n, input string name);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      d         = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      checks++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_valid cycle=%0d got a=%b b=%b want 0", name, i, valid_a, valid_b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; d = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (valid_a !== 1'b0 || count_a !== '0 || ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_wide got v=%b c=%0d o=%b want 0", valid_a, count_a, ovf_a);
    end
    checks++;
    if (valid_b !== 1'b0 || count_b !== '0 || ovf_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_narrow got v=%b c=%0d o=%b want 0", valid_b, count_b, ovf_b);
    end
    rst = 1'b0;
    expect_quiet(3, "reset_idle");
  endtask

  task automatic test_basic_toggle();
    expect_quiet(1, "basic_pre");
    d = 1'b0;
    start_idle(1'b0);
    count_window(16'h5555, -1, "basic_toggle");
    handshake(1'b0, 1'b0, "basic_hs");
  endtask

  task automatic test_saturation();
    start_idle(1'b0);
    count_window(16'h0555, -1, "sat_six");  // six rising edges
    handshake(1'b0, 1'b0, "sat_hs");
    start_idle(1'b0);
    count_window(16'h0015, -1, "sat_three");  // exactly at narrow max
    handshake(1'b0, 1'b0, "sat3_hs");
  endtask

  task automatic test_backpressure();
    logic [CW_A-1:0] held_a;
    logic [CW_B-1:0] held_b;
    start_idle(1'($urandom));
    count_window(16'($urandom), -1, "bp_first");
    held_a = count_a;
    held_b = count_b;
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      en        = 1'($urandom);
      d         = 1'($urandom);
      tick();
      checks++;
      if (valid_a !== 1'b1 || valid_b !== 1'b1 || count_a !== CW_A'(exp_a) ||
          count_b !== CW_B'(exp_b) || ovf_a !== exp_ovf_a || ovf_b !== exp_ovf_b) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%b%b ca=%0d cb=%0d want v=11 ca=%0d cb=%0d",
                 i, valid_a, valid_b, count_a, count_b, held_a, held_b);
      end
    end
    handshake(1'b1, 1'($urandom), "bp_hs");
    count_window(16'($urandom), -1, "bp_second");
    handshake(1'b0, 1'b0, "bp_hs2");
  endtask

  task automatic test_boundary();
    start_idle(1'b0);
    count_window(16'h8000, -1, "edge_last_cycle");
    // Rise while holding, and stay high: must not be counted next window.
    d = 1'b1; out_ready = 1'b0; en = 1'b1;
    tick();
    handshake(1'b1, 1'b1, "boundary_hs");
    count_window(16'hFFFF, -1, "edge_after_window");
    handshake(1'b0, 1'b1, "boundary_hs2");
  endtask

  task automatic test_reset_mid_window();
    logic [8:0] p = 9'b1_0101_0101;  // five rising edges
    start_idle(1'b0);
    for (int i = 0; i < 9; i++) begin
      d   = p[i];
      rst = (i == 8);
      tick();
    end
    rst = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || count_a !== '0 || ovf_a !== 1'b0 ||
        valid_b !== 1'b0 || count_b !== '0 || ovf_b !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got va=%b ca=%0d oa=%b vb=%b cb=%0d ob=%b want 0",
               valid_a, count_a, ovf_a, valid_b, count_b, ovf_b);
    end
    expect_quiet(WIN + 2, "rst_mid_idle");
    start_idle(1'b0);
    count_window(16'h0003, -1, "rst_mid_next");
    handshake(1'b0, 1'b0, "rst_mid_hs");
  endtask

  task automatic test_en_drop();
    start_idle(1'($urandom));
    count_window(16'($urandom), 3, "en_drop");
    handshake(1'b0, 1'b0, "en_drop_hs");
    expect_quiet(WIN + 3, "en_drop_idle");
  endtask

  task automatic test_random_windows();
    for (int k = 0; k < 6; k++) begin
      start_idle(1'($urandom));
      count_window(16'($urandom), -1, "random");
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'b0; d = 1'($urandom); tick();
      end
      handshake(1'($urandom), 1'($urandom), "random_hs");
      if (valid_a === 1'b0 && en === 1'b1) begin
        count_window(16'($urandom), -1, "random_b2b");
        handshake(1'b0, 1'b0, "random_b2b_hs");
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_toggle();
    test_saturation();
    test_backpressure();
    test_boundary();
    test_reset_mid_window();
    test_en_drop();
    test_random_windows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_edge_counter
`default_nettype wire
